// File: rtl/gpu_pkg.sv
// Shared encodings and default widths for the core phase and the instruction fetcher.
package gpu_pkg;

    localparam int unsigned DEFAULT_PROGRAM_ADDR_BITS = 8;
    localparam int unsigned DEFAULT_PROGRAM_DATA_BITS = 16;
    localparam int unsigned STATE_BITS                = 3;

    typedef enum logic [STATE_BITS-1:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_e;

    typedef enum logic [STATE_BITS-1:0] {
        FETCHER_IDLE     = 3'b000,
        FETCHER_FETCHING = 3'b001,
        FETCHER_FETCHED  = 3'b010
    } fetcher_state_e;

endpackage

// File: rtl/fetch_line_buffer.sv
// Single-entry {valid, pc, instruction} record of the most recent completed fetch.
module fetch_line_buffer
    import gpu_pkg::*;
#(
    parameter int unsigned PROGRAM_ADDR_BITS = DEFAULT_PROGRAM_ADDR_BITS,
    parameter int unsigned PROGRAM_DATA_BITS = DEFAULT_PROGRAM_DATA_BITS
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [PROGRAM_ADDR_BITS-1:0] wr_pc,
    input  logic [PROGRAM_DATA_BITS-1:0] wr_data,
    input  logic [PROGRAM_ADDR_BITS-1:0] lookup_pc,
    output logic                         hit_c,
    output logic [PROGRAM_DATA_BITS-1:0] data
);

    logic                         r_valid;
    logic [PROGRAM_ADDR_BITS-1:0] r_tag;
    logic [PROGRAM_DATA_BITS-1:0] r_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (wr_en) begin
            r_valid <= 1'b1;
            r_tag   <= wr_pc;
            r_data  <= wr_data;
        end
    end

    assign hit_c = r_valid && (r_tag == lookup_pc);
    assign data  = r_data;

endmodule

// File: rtl/fetcher.sv
// Instruction fetcher: issues one program-memory read per core FETCH phase and holds the result.
// Optional single-entry line buffer enabled by defining FETCHER_LINE_BUFFER_EN.
module fetcher
    import gpu_pkg::*;
#(
    parameter int unsigned PROGRAM_ADDR_BITS = DEFAULT_PROGRAM_ADDR_BITS,
    parameter int unsigned PROGRAM_DATA_BITS = DEFAULT_PROGRAM_DATA_BITS
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [STATE_BITS-1:0]        core_state,
    input  logic [PROGRAM_ADDR_BITS-1:0] current_pc,
    output logic                         mem_read_valid,
    output logic [PROGRAM_ADDR_BITS-1:0] mem_read_address,
    input  logic                         mem_read_ready,
    input  logic [PROGRAM_DATA_BITS-1:0] mem_read_data,
    output logic [STATE_BITS-1:0]        fetcher_state,
    output logic [PROGRAM_DATA_BITS-1:0] instruction
);

    fetcher_state_e               r_state;
    logic                         r_valid;
    logic [PROGRAM_ADDR_BITS-1:0] r_address;
    logic [PROGRAM_DATA_BITS-1:0] r_instruction;

    logic                         w_hit;
    logic [PROGRAM_DATA_BITS-1:0] w_buf_data;
    logic                         w_complete;

    assign w_complete = enable && (r_state == FETCHER_FETCHING) && mem_read_ready;

`ifdef FETCHER_LINE_BUFFER_EN
    fetch_line_buffer #(
        .PROGRAM_ADDR_BITS(PROGRAM_ADDR_BITS),
        .PROGRAM_DATA_BITS(PROGRAM_DATA_BITS)
    ) u_line_buffer (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (w_complete),
        .wr_pc     (r_address),
        .wr_data   (mem_read_data),
        .lookup_pc (current_pc),
        .hit_c     (w_hit),
        .data      (w_buf_data)
    );
`else
    assign w_hit      = 1'b0;
    assign w_buf_data = '0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= FETCHER_IDLE;
            r_valid       <= 1'b0;
            r_address     <= '0;
            r_instruction <= '0;
        end else if (enable) begin
            case (r_state)
                FETCHER_IDLE: begin
                    if (core_state == STATE_BITS'(CORE_FETCH)) begin
                        if (w_hit) begin
                            // Buffer hit: skip memory, instruction comes from the stored line.
                            r_instruction <= w_buf_data;
                            r_state       <= FETCHER_FETCHED;
                        end else begin
                            r_valid   <= 1'b1;
                            r_address <= current_pc;
                            r_state   <= FETCHER_FETCHING;
                        end
                    end
                end
                FETCHER_FETCHING: begin
                    if (w_complete) begin
                        r_instruction <= mem_read_data;
                        r_valid       <= 1'b0;
                        r_state       <= FETCHER_FETCHED;
                    end
                end
                FETCHER_FETCHED: begin
                    if (core_state == STATE_BITS'(CORE_DECODE)) begin
                        r_state <= FETCHER_IDLE;
                    end
                end
                default: begin
                    r_state <= FETCHER_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign mem_read_valid   = r_valid;
    assign mem_read_address = r_address;
    assign fetcher_state    = r_state;
    assign instruction      = r_instruction;

endmodule

// File: tb/tb_fetcher.sv
// Self-checking bench for fetcher: stimulus table plus hand sequences, with a scoreboard
// of returned memory words checked whenever a fetch completes.
module tb_fetcher;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;

    localparam logic [2:0] S_IDLE = 3'b000;
    localparam logic [2:0] S_FING = 3'b001;
    localparam logic [2:0] S_FED  = 3'b010;

    localparam logic [2:0] C_IDLE = 3'b000;
    localparam logic [2:0] C_FETCH = 3'b001;
    localparam logic [2:0] C_DECODE = 3'b010;
    localparam logic [2:0] C_EXEC = 3'b101;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic [2:0]    core_state;
    logic [AW-1:0] current_pc;
    logic          mem_read_valid;
    logic [AW-1:0] mem_read_address;
    logic          mem_read_ready;
    logic [DW-1:0] mem_read_data;
    logic [2:0]    fetcher_state;
    logic [DW-1:0] instruction;

    fetcher dut (
        .clock            (clock),
        .reset            (reset),
        .enable           (enable),
        .core_state       (core_state),
        .current_pc       (current_pc),
        .mem_read_valid   (mem_read_valid),
        .mem_read_address (mem_read_address),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data),
        .fetcher_state    (fetcher_state),
        .instruction      (instruction)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          rst;
        logic          en;
        logic [2:0]    cs;
        logic [AW-1:0] pc;
        logic          rdy;
        logic [DW-1:0] data;
        logic [2:0]    e_state;
        logic          e_valid;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_instr;
    } vec_t;

    int            checks   = 0;
    int            failures = 0;
    logic [2:0]    prev_exp = S_IDLE;
    logic [DW-1:0] sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, compare all outputs and the scoreboard.
    task automatic apply(input string tag, input vec_t v);
        logic [DW-1:0] exp_word;
        reset          = v.rst;
        enable         = v.en;
        core_state     = v.cs;
        current_pc     = v.pc;
        mem_read_ready = v.rdy;
        mem_read_data  = v.data;
        if (v.rdy && v.en && !v.rst && prev_exp == S_FING)
            sb_q.push_back(v.data);
        @(posedge clock);
        #1;
        chk({tag, ".state"}, 32'(fetcher_state), 32'(v.e_state));
        chk({tag, ".valid"}, 32'(mem_read_valid), 32'(v.e_valid));
        chk({tag, ".addr"},  32'(mem_read_address), 32'(v.e_addr));
        chk({tag, ".instr"}, 32'(instruction), 32'(v.e_instr));
        if (v.e_state == S_FED && prev_exp == S_FING) begin
            if (sb_q.size() == 0) begin
                chk({tag, ".sb_empty"}, 32'(1), 32'(0));
            end else begin
                exp_word = sb_q.pop_front();
                chk({tag, ".sb"}, 32'(instruction), 32'(exp_word));
            end
        end
        prev_exp = v.rst ? S_IDLE : v.e_state;
    endtask

    vec_t tbl[$];

    initial begin
        // rst en cs pc rdy data | state valid addr instr
        tbl.push_back('{1, 1, C_IDLE,   8'd0,  0, 16'h0000, S_IDLE, 0, 8'd0,  16'h0000});
        tbl.push_back('{0, 1, C_IDLE,   8'd10, 0, 16'h0000, S_IDLE, 0, 8'd0,  16'h0000});
        tbl.push_back('{0, 1, C_IDLE,   8'd10, 1, 16'hFFFF, S_IDLE, 0, 8'd0,  16'h0000});
        tbl.push_back('{0, 1, C_FETCH,  8'd10, 0, 16'h0000, S_FING, 1, 8'd10, 16'h0000});
        tbl.push_back('{0, 1, C_FETCH,  8'd10, 0, 16'h0000, S_FING, 1, 8'd10, 16'h0000});
        tbl.push_back('{0, 1, C_DECODE, 8'd77, 0, 16'h0000, S_FING, 1, 8'd10, 16'h0000});
        tbl.push_back('{0, 1, C_DECODE, 8'd77, 0, 16'h0000, S_FING, 1, 8'd10, 16'h0000});
        tbl.push_back('{0, 1, C_DECODE, 8'd77, 1, 16'h3A5C, S_FED,  0, 8'd10, 16'h3A5C});
        tbl.push_back('{0, 1, C_EXEC,   8'd10, 1, 16'h1111, S_FED,  0, 8'd10, 16'h3A5C});
        tbl.push_back('{0, 1, C_DECODE, 8'd10, 0, 16'h0000, S_IDLE, 0, 8'd10, 16'h3A5C});
        tbl.push_back('{0, 1, C_IDLE,   8'd10, 1, 16'hBEEF, S_IDLE, 0, 8'd10, 16'h3A5C});
        tbl.push_back('{0, 1, C_FETCH,  8'd11, 1, 16'h9999, S_FING, 1, 8'd11, 16'h3A5C});
        tbl.push_back('{0, 1, C_DECODE, 8'd11, 1, 16'h1234, S_FED,  0, 8'd11, 16'h1234});
        tbl.push_back('{0, 1, C_DECODE, 8'd11, 0, 16'h0000, S_IDLE, 0, 8'd11, 16'h1234});

        foreach (tbl[i]) apply($sformatf("tbl%0d", i), tbl[i]);

        // Enable low mid-fetch with ready high: nothing captured until enable returns.
        apply("frz.req", '{0, 1, C_FETCH, 8'd20, 0, 16'h0000, S_FING, 1, 8'd20, 16'h1234});
        for (int k = 0; k < 5; k++)
            apply($sformatf("frz.hold%0d", k),
                  '{0, 0, C_FETCH, 8'd21, 1, 16'h5555, S_FING, 1, 8'd20, 16'h1234});
        apply("frz.cap", '{0, 1, C_FETCH, 8'd21, 1, 16'h5555, S_FED, 0, 8'd20, 16'h5555});
        apply("frz.hold_fed", '{0, 0, C_DECODE, 8'd21, 0, 16'h0000, S_FED, 0, 8'd20, 16'h5555});

        // Reset with nonzero outputs, overriding enable=0.
        apply("rst.ovr", '{1, 0, C_DECODE, 8'd21, 0, 16'h0000, S_IDLE, 0, 8'd0, 16'h0000});

        // Reset mid-fetch abandons the request; later ready is ignored.
        apply("rstf.req", '{0, 1, C_FETCH, 8'd30, 0, 16'h0000, S_FING, 1, 8'd30, 16'h0000});
        apply("rstf.rst", '{1, 1, C_FETCH, 8'd30, 0, 16'h0000, S_IDLE, 0, 8'd0,  16'h0000});
        apply("rstf.rdy", '{0, 1, C_IDLE,  8'd30, 1, 16'hAAAA, S_IDLE, 0, 8'd0,  16'h0000});

        // Fetch pc=10 twice; only the line-buffer build skips the second memory request.
        apply("lb.req1", '{0, 1, C_FETCH,  8'd10, 0, 16'h0000, S_FING, 1, 8'd10, 16'h0000});
        apply("lb.cap1", '{0, 1, C_FETCH,  8'd10, 1, 16'h3A5C, S_FED,  0, 8'd10, 16'h3A5C});
        apply("lb.dec1", '{0, 1, C_DECODE, 8'd10, 0, 16'h0000, S_IDLE, 0, 8'd10, 16'h3A5C});
        apply("lb.dec2", '{0, 1, C_DECODE, 8'd10, 0, 16'h0000, S_IDLE, 0, 8'd10, 16'h3A5C});
`ifdef FETCHER_LINE_BUFFER_EN
        apply("lb.hit",  '{0, 1, C_FETCH,  8'd10, 1, 16'h7777, S_FED,  0, 8'd10, 16'h3A5C});
        apply("lb.hdec", '{0, 1, C_DECODE, 8'd10, 0, 16'h0000, S_IDLE, 0, 8'd10, 16'h3A5C});
`else
        apply("lb.req2", '{0, 1, C_FETCH,  8'd10, 0, 16'h0000, S_FING, 1, 8'd10, 16'h3A5C});
        apply("lb.cap2", '{0, 1, C_FETCH,  8'd10, 1, 16'h3A5C, S_FED,  0, 8'd10, 16'h3A5C});
        apply("lb.dec3", '{0, 1, C_DECODE, 8'd10, 0, 16'h0000, S_IDLE, 0, 8'd10, 16'h3A5C});
`endif
        apply("lb.miss", '{0, 1, C_FETCH,  8'd11, 0, 16'h0000, S_FING, 1, 8'd11, 16'h3A5C});
        apply("lb.cap3", '{0, 1, C_FETCH,  8'd11, 1, 16'h0B0B, S_FED,  0, 8'd11, 16'h0B0B});
        apply("lb.dec4", '{0, 1, C_DECODE, 8'd11, 0, 16'h0000, S_IDLE, 0, 8'd11, 16'h0B0B});

        chk("sb.drained", 32'(sb_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetcher.md
FETCHER -- requirements
Module: fetcher

Interface
- REQ-001: The block SHALL have parameter PROGRAM_ADDR_BITS, default 8, program-memory address width; matches the pc_nzp current_pc/next_pc width.
- REQ-002: The block SHALL have parameter PROGRAM_DATA_BITS, default 16, instruction word width.
- REQ-003: The block SHALL use one clock and a synchronous, active-high reset; ports are named clock and reset.
- REQ-004: The ports SHALL be:
  - clock  in  1  system clock.
- REQ-005: reset  in  1  synchronous active-high reset.
- REQ-006: enable  in  1  block active; when low, state and outputs hold.
- REQ-007: core_state  in  3  core phase: IDLE=000, FETCH=001, DECODE=010, REQUEST=011, WAIT=100, EXECUTE=101, UPDATE=110, DONE=111.
- REQ-008: current_pc  in  PROGRAM_ADDR_BITS  PC of the instruction to fetch; driven by pc_nzp via core.
- REQ-009: mem_read_valid  out  1  program-memory read request.
- REQ-010: mem_read_address  out  PROGRAM_ADDR_BITS  request address.
- REQ-011: mem_read_ready  in  1  memory response strobe; data valid this cycle.
- REQ-012: mem_read_data  in  PROGRAM_DATA_BITS  returned instruction.
- REQ-013: fetcher_state  out  3  IDLE=000, FETCHING=001, FETCHED=010.
- REQ-014: instruction  out  PROGRAM_DATA_BITS  last fetched instruction, held until the next fetch completes.

Function
- REQ-015: IDLE, enable=1, core_state=FETCH: next edge sets mem_read_valid=1 and mem_read_address=current_pc; state becomes FETCHING.
- REQ-016: FETCHING: mem_read_valid and mem_read_address SHALL hold stable until the edge on which mem_read_ready=1 is sampled.
- REQ-017: FETCHING with mem_read_ready=1: same edge captures mem_read_data into instruction, clears mem_read_valid, and moves to FETCHED.
- REQ-018: Minimum latency SHALL be FETCH sampled to FETCHED = 2 edges when memory returns ready on the first FETCHING cycle.
- REQ-019: FETCHED with core_state=DECODE: next edge moves to IDLE; instruction is unchanged.
- REQ-020: mem_read_ready asserted outside FETCHING SHALL be ignored.
- REQ-021: core_state leaving FETCH while FETCHING SHALL NOT abort the request; completion proceeds per REQ-017.
- REQ-022: In IDLE with core_state other than FETCH, the state SHALL remain IDLE and no request is issued.
- REQ-023: enable=0 SHALL freeze state, mem_read_valid, address and instruction, including mid-FETCHING.
- REQ-024: Unused encoding 011–111 on internal state SHALL return to IDLE on the next edge.

Reset
- REQ-025: When reset=1 at an edge, fetcher_state=IDLE, mem_read_valid=0, mem_read_address=0, instruction=0; reset overrides enable.
- REQ-026: Reset mid-FETCHING SHALL abandon the request: mem_read_valid=0 after that edge; a later mem_read_ready is ignored.

Configuration
- REQ-027: Macro FETCHER_LINE_BUFFER_EN, when defined, SHALL add a single-entry buffer holding {valid, pc, instruction} of the last completed fetch.
- REQ-028: With FETCHER_LINE_BUFFER_EN, FETCH in IDLE with buffer valid and tag==current_pc SHALL go directly to FETCHED next edge, load instruction from the buffer, and leave mem_read_valid=0.
- REQ-029: With FETCHER_LINE_BUFFER_EN, each REQ-017 completion SHALL overwrite the buffer; reset SHALL clear buffer valid.
- REQ-030: Without FETCHER_LINE_BUFFER_EN, every FETCH SHALL issue a memory request; no buffer storage exists.

Structure
- REQ-031: Core-state and fetcher-state encodings and default widths SHALL live in shared package gpu_pkg.
- REQ-032: The buffer SHALL be sub-module fetch_line_buffer, instantiated only under FETCHER_LINE_BUFFER_EN.

Verification
- REQ-033: Reset with outputs forced nonzero -> state=000, valid=0, address=0, instruction=0 after one edge.
- REQ-034: current_pc=10, FETCH; ready after 3 FETCHING cycles with data=0x3A5C -> valid high 4 cycles, address=10 stable, instruction=0x3A5C, state=FETCHED.
- REQ-035: FETCHED, then DECODE -> IDLE next edge, instruction still 0x3A5C; stray ready pulse in IDLE -> no change.
- REQ-036: enable=0 for 5 cycles mid-FETCHING with ready=1 -> nothing captured; enable=1 -> capture on the next edge.
- REQ-037: Reset asserted in FETCHING, then ready=1 -> valid=0, state IDLE, instruction=0.
- REQ-038: With FETCHER_LINE_BUFFER_EN, fetch pc=10 twice -> second fetch shows no mem_read_valid, reaches FETCHED in 1 edge, instruction=0x3A5C; pc=11 -> memory request issued.
